// File: rtl/bp_perf_monitor_if.sv
// Bus bundle for bp_perf_monitor.
// Carries everything except clock and reset. The master side drives
// the control and event inputs and the read request. The slave side,
// the monitor, returns read data, the window-done pulse and the
// sticky overflow flags.
//   en_i, clear_i, instr_vld_i     control / shared event inputs
//   br_vld_i, br_miss_i            per-channel branch events
//   rd_req_i, rd_ch_i, rd_sel_i    read request
//   rd_ack_o, rd_data_o            read response
//   win_done_o, ovf_o              status
interface bp_perf_monitor_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                 en_i;
    logic                 clear_i;
    logic                 instr_vld_i;
    logic [NUM_CH-1:0]    br_vld_i;
    logic [NUM_CH-1:0]    br_miss_i;
    logic                 rd_req_i;
    logic [CH_W-1:0]      rd_ch_i;
    logic [1:0]           rd_sel_i;
    logic                 rd_ack_o;
    logic [CNT_WIDTH-1:0] rd_data_o;
    logic                 win_done_o;
    logic [NUM_CH-1:0]    ovf_o;

    modport master (
        output en_i, clear_i, instr_vld_i, br_vld_i, br_miss_i,
               rd_req_i, rd_ch_i, rd_sel_i,
        input  rd_ack_o, rd_data_o, win_done_o, ovf_o
    );

    modport slave (
        input  en_i, clear_i, instr_vld_i, br_vld_i, br_miss_i,
               rd_req_i, rd_ch_i, rd_sel_i,
        output rd_ack_o, rd_data_o, win_done_o, ovf_o
    );
endinterface

// File: rtl/bp_perf_monitor.sv
// Multi-channel branch-predictor performance monitor.
// Per channel it counts resolved branches and mispredictions. It also
// counts global cycles and valid instructions. Every WINDOW_LEN counted
// cycles the live counts are copied into shadow registers and the live
// counts restart from zero. Reads return the shadow copy. When
// WINDOW_LEN is 0, reads return the live counts instead.
// Ports:
//   clk_i   rising-edge clock
//   rst_i   synchronous reset, active high
//   bus     bp_perf_monitor_if.slave (events, control, read port, status)
//
// state | meaning
// IDLE  | not counting; window position and live counts held
// RUN   | counting
// SNAP  | last counted cycle of a window; live+events -> shadow, live -> 0
module bp_perf_monitor #(
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int WINDOW_LEN = 1024,
    parameter int SATURATE   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    bp_perf_monitor_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WL_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [WL_W-1:0] WIN_RELOAD = (WINDOW_LEN > 1) ? WL_W'(WINDOW_LEN - 1) : '0;
    localparam bit SNAP_EN = (WINDOW_LEN != 0);

    typedef logic [CNT_WIDTH-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, RUN, SNAP} state_t;

    state_t            state;
    logic [WL_W-1:0]   win_left;
    logic [WL_W-1:0]   win_nxt;
    logic              snap_due;

    cnt_t              br_live   [NUM_CH];
    cnt_t              miss_live [NUM_CH];
    cnt_t              cyc_live;
    cnt_t              ins_live;
    cnt_t              br_shd    [NUM_CH];
    cnt_t              miss_shd  [NUM_CH];
    cnt_t              cyc_shd;
    cnt_t              ins_shd;

    cnt_t              br_nxt    [NUM_CH];
    cnt_t              miss_nxt  [NUM_CH];
    cnt_t              cyc_nxt;
    cnt_t              ins_nxt;
    logic [NUM_CH-1:0] ovf_evt;
    logic [NUM_CH-1:0] ovf;

    logic              rd_ack;
    cnt_t              rd_data;
    cnt_t              rd_mux;
    logic              win_done;

    function automatic cnt_t bump(input cnt_t v, input logic inc);
        if (!inc)
            return v;
        if (&v)
            return (SATURATE != 0) ? v : '0;
        return v + cnt_t'(1);
    endfunction

    // win_left counts the counted cycles still to come in the window
    // after the current one. SNAP is the counted cycle where it reaches 0.
    // Because the next state depends on its next value, a WINDOW_LEN of 1
    // stays in SNAP.
    always_comb begin
        win_nxt = win_left;
        if (bus.clear_i || state == SNAP)
            win_nxt = WIN_RELOAD;
        else if (state == RUN)
            win_nxt = win_left - WL_W'(1);
        snap_due = SNAP_EN && (win_nxt == '0);
    end

    always_comb begin
        ovf_evt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            br_nxt[c]   = bump(br_live[c], bus.br_vld_i[c]);
            miss_nxt[c] = bump(miss_live[c], bus.br_vld_i[c] & bus.br_miss_i[c]);
            ovf_evt[c]  = (bus.br_vld_i[c] & (&br_live[c]))
                        | (bus.br_vld_i[c] & bus.br_miss_i[c] & (&miss_live[c]));
        end
        cyc_nxt = bump(cyc_live, 1'b1);
        ins_nxt = bump(ins_live, bus.instr_vld_i);
    end

    // Out-of-range channels match no entry and read as zero.
    always_comb begin
        rd_mux = '0;
        case (bus.rd_sel_i)
            2'd0: begin
                for (int c = 0; c < NUM_CH; c++)
                    if (bus.rd_ch_i == CH_W'(c))
                        rd_mux = SNAP_EN ? br_shd[c] : br_live[c];
            end
            2'd1: begin
                for (int c = 0; c < NUM_CH; c++)
                    if (bus.rd_ch_i == CH_W'(c))
                        rd_mux = SNAP_EN ? miss_shd[c] : miss_live[c];
            end
            2'd2:    rd_mux = SNAP_EN ? cyc_shd : cyc_live;
            default: rd_mux = SNAP_EN ? ins_shd : ins_live;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            win_left <= WIN_RELOAD;
            cyc_live <= '0;
            ins_live <= '0;
            cyc_shd  <= '0;
            ins_shd  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                br_live[c]   <= '0;
                miss_live[c] <= '0;
                br_shd[c]    <= '0;
                miss_shd[c]  <= '0;
            end
            ovf      <= '0;
            rd_ack   <= 1'b0;
            rd_data  <= '0;
            win_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en_i)
                        state <= snap_due ? SNAP : RUN;
                end
                RUN, SNAP: begin
                    if (!bus.en_i)
                        state <= IDLE;
                    else
                        state <= snap_due ? SNAP : RUN;
                end
                default: state <= IDLE;
            endcase

            win_left <= win_nxt;
            rd_ack   <= bus.rd_req_i;
            rd_data  <= bus.rd_req_i ? rd_mux : '0;
            win_done <= 1'b0;

            // clear_i also swallows a snapshot due in the same cycle.
            if (bus.clear_i) begin
                cyc_live <= '0;
                ins_live <= '0;
                cyc_shd  <= '0;
                ins_shd  <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    br_live[c]   <= '0;
                    miss_live[c] <= '0;
                    br_shd[c]    <= '0;
                    miss_shd[c]  <= '0;
                end
                ovf <= '0;
            end else if (state == SNAP) begin
                cyc_shd  <= cyc_nxt;
                ins_shd  <= ins_nxt;
                cyc_live <= '0;
                ins_live <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    br_shd[c]    <= br_nxt[c];
                    miss_shd[c]  <= miss_nxt[c];
                    br_live[c]   <= '0;
                    miss_live[c] <= '0;
                end
                ovf      <= ovf | ovf_evt;
                win_done <= 1'b1;
            end else if (state == RUN) begin
                cyc_live <= cyc_nxt;
                ins_live <= ins_nxt;
                for (int c = 0; c < NUM_CH; c++) begin
                    br_live[c]   <= br_nxt[c];
                    miss_live[c] <= miss_nxt[c];
                end
                ovf <= ovf | ovf_evt;
            end
        end
    end

    assign bus.rd_ack_o   = rd_ack;
    assign bus.rd_data_o  = rd_data;
    assign bus.win_done_o = win_done;
    assign bus.ovf_o      = ovf;
endmodule

// File: tb/tb_bp_perf_monitor.sv
// Directed testbench for bp_perf_monitor.
// dut_a: 3 channels, 16-bit counters, 8-cycle windows, saturating.
// dut_s / dut_w: 2 channels, 4-bit counters, free-running, saturating / wrapping.
module tb_bp_perf_monitor;
    logic clk = 1'b0;
    logic rst;
    int   n_run = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    bp_perf_monitor_if #(.NUM_CH(3), .CNT_WIDTH(16)) ifa ();
    bp_perf_monitor_if #(.NUM_CH(2), .CNT_WIDTH(4))  ifs ();
    bp_perf_monitor_if #(.NUM_CH(2), .CNT_WIDTH(4))  ifw ();

    bp_perf_monitor #(.NUM_CH(3), .CNT_WIDTH(16), .WINDOW_LEN(8), .SATURATE(1))
        dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
    bp_perf_monitor #(.NUM_CH(2), .CNT_WIDTH(4), .WINDOW_LEN(0), .SATURATE(1))
        dut_s (.clk_i(clk), .rst_i(rst), .bus(ifs));
    bp_perf_monitor #(.NUM_CH(2), .CNT_WIDTH(4), .WINDOW_LEN(0), .SATURATE(0))
        dut_w (.clk_i(clk), .rst_i(rst), .bus(ifw));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One cycle on dut_a: drive read request and channel events, then check
    // the response, read data and window-done pulse of the following cycle.
    task automatic a_cycle(input logic req, input logic [1:0] ch, input logic [1:0] sel,
                           input logic [2:0] vld, input logic [31:0] exp_data,
                           input logic exp_wd, input string tag);
        ifa.rd_req_i = req;
        ifa.rd_ch_i  = ch;
        ifa.rd_sel_i = sel;
        ifa.br_vld_i = vld;
        step();
        chk({tag, "_ack"},  {31'd0, ifa.rd_ack_o}, {31'd0, req});
        chk({tag, "_data"}, {16'd0, ifa.rd_data_o}, exp_data);
        chk({tag, "_wd"},   {31'd0, ifa.win_done_o}, {31'd0, exp_wd});
    endtask

    task automatic s_set(input logic en, input logic [1:0] vld, input logic [1:0] miss,
                         input logic ins, input logic clr);
        ifs.en_i = en;  ifs.br_vld_i = vld;  ifs.br_miss_i = miss;
        ifs.instr_vld_i = ins;  ifs.clear_i = clr;
        ifw.en_i = en;  ifw.br_vld_i = vld;  ifw.br_miss_i = miss;
        ifw.instr_vld_i = ins;  ifw.clear_i = clr;
    endtask

    task automatic s_rd(input logic ch, input logic [1:0] sel,
                        input logic [31:0] exp_s, input logic [31:0] exp_w, input string tag);
        ifs.rd_req_i = 1'b1;  ifs.rd_ch_i = ch;  ifs.rd_sel_i = sel;
        ifw.rd_req_i = 1'b1;  ifw.rd_ch_i = ch;  ifw.rd_sel_i = sel;
        step();
        chk({tag, "_sat_ack"},  {31'd0, ifs.rd_ack_o}, 32'd1);
        chk({tag, "_sat_data"}, {28'd0, ifs.rd_data_o}, exp_s);
        chk({tag, "_wrap_ack"}, {31'd0, ifw.rd_ack_o}, 32'd1);
        chk({tag, "_wrap_data"}, {28'd0, ifw.rd_data_o}, exp_w);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        ifa.en_i = 0; ifa.clear_i = 0; ifa.instr_vld_i = 0; ifa.br_vld_i = '0;
        ifa.br_miss_i = '0; ifa.rd_req_i = 0; ifa.rd_ch_i = '0; ifa.rd_sel_i = '0;
        s_set(0, 2'b00, 2'b00, 0, 0);
        ifs.rd_req_i = 0; ifs.rd_ch_i = '0; ifs.rd_sel_i = '0;
        ifw.rd_req_i = 0; ifw.rd_ch_i = '0; ifw.rd_sel_i = '0;
        repeat (3) step();
        chk("init_ack",  {31'd0, ifa.rd_ack_o}, 0);
        chk("init_data", {16'd0, ifa.rd_data_o}, 0);
        chk("init_wd",   {31'd0, ifa.win_done_o}, 0);
        chk("init_ovf",  {29'd0, ifa.ovf_o}, 0);

        // Window 1: cycle 0 is IDLE, cycles 1..8 are counted, 8 is SNAP.
        rst = 1'b0;
        ifa.en_i = 1'b1;
        ifa.br_vld_i = 3'b010;
        cyc = 0;
        step();
        for (int k = 1; k <= 8; k++) begin
            chk("w1_wd_early", {31'd0, ifa.win_done_o}, 0);
            ifa.br_vld_i  = 3'b010 | ((k == 3) ? 3'b001 : 3'b000) | ((k == 8) ? 3'b100 : 3'b000);
            ifa.br_miss_i = ((k == 2 || k == 4 || k == 6) ? 3'b010 : 3'b000)
                          | ((k == 3 || k == 5) ? 3'b001 : 3'b000)
                          | ((k == 8) ? 3'b100 : 3'b000);
            ifa.instr_vld_i = (k % 2 == 1);
            step();
        end
        chk("w1_wd", {31'd0, ifa.win_done_o}, 1);
        ifa.br_miss_i = '0;
        ifa.instr_vld_i = 1'b0;

        // Reads of window-1 snapshot while window 2 (cycles 9..16) runs.
        a_cycle(1, 2'd1, 2'd0, 3'b001, 8, 0, "w1_br1");
        a_cycle(1, 2'd1, 2'd1, 3'b001, 3, 0, "w1_ms1");
        a_cycle(1, 2'd2, 2'd2, 3'b000, 8, 0, "w1_cyc");
        a_cycle(1, 2'd0, 2'd3, 3'b000, 4, 0, "w1_ins");
        a_cycle(1, 2'd0, 2'd0, 3'b000, 1, 0, "w1_br0");
        a_cycle(1, 2'd2, 2'd1, 3'b000, 1, 0, "w1_ms2");
        a_cycle(1, 2'd3, 2'd0, 3'b000, 0, 0, "ch_oor");
        a_cycle(1, 2'd2, 2'd0, 3'b000, 1, 1, "rd_on_snap");
        a_cycle(1, 2'd0, 2'd0, 3'b000, 2, 0, "w2_br0");
        a_cycle(1, 2'd1, 2'd2, 3'b000, 8, 0, "w2_cyc");
        a_cycle(1, 2'd1, 2'd0, 3'b000, 0, 0, "w2_br1");
        a_cycle(0, 2'd0, 2'd0, 3'b000, 0, 0, "rd_idle");

        // Window 3 (from cycle 17): en_i low for cycles 21..25 delays SNAP to 29.
        while (cyc < 32) begin
            ifa.en_i = !(cyc >= 21 && cyc <= 25);
            ifa.instr_vld_i = 1'b1;
            step();
            chk("en_gap_wd", {31'd0, ifa.win_done_o}, {31'd0, cyc == 30});
        end
        a_cycle(1, 2'd0, 2'd2, 3'b010, 8, 0, "w3_cyc");
        a_cycle(1, 2'd0, 2'd3, 3'b010, 4, 0, "w3_ins");
        for (int k = 0; k < 3; k++)
            a_cycle(0, 2'd0, 2'd0, 3'b010, 0, 0, "w4_run");

        // clear_i on the window-4 SNAP cycle (37).
        ifa.clear_i = 1'b1;
        a_cycle(0, 2'd0, 2'd0, 3'b010, 0, 0, "clr_snap");
        ifa.clear_i = 1'b0;
        a_cycle(1, 2'd1, 2'd0, 3'b010, 0, 0, "clr_br1");
        a_cycle(1, 2'd0, 2'd2, 3'b010, 0, 0, "clr_cyc");
        for (int k = 0; k < 5; k++)
            a_cycle(0, 2'd0, 2'd0, 3'b010, 0, 0, "w5_run");
        a_cycle(0, 2'd0, 2'd0, 3'b010, 0, 1, "w5_wd");
        a_cycle(1, 2'd1, 2'd0, 3'b010, 8, 0, "w5_br1");
        a_cycle(1, 2'd0, 2'd3, 3'b010, 8, 0, "w5_ins");
        chk("a_ovf", {29'd0, ifa.ovf_o}, 0);

        // Reset mid-RUN with a read pending.
        rst = 1'b1;
        ifa.rd_req_i = 1'b1;
        ifa.rd_ch_i = 2'd1;
        ifa.rd_sel_i = 2'd0;
        step();
        rst = 1'b0;
        chk("rst_ack",  {31'd0, ifa.rd_ack_o}, 0);
        chk("rst_data", {16'd0, ifa.rd_data_o}, 0);
        chk("rst_wd",   {31'd0, ifa.win_done_o}, 0);
        chk("rst_ovf",  {29'd0, ifa.ovf_o}, 0);
        a_cycle(1, 2'd1, 2'd0, 3'b010, 0, 0, "rst_br1");
        a_cycle(1, 2'd0, 2'd2, 3'b010, 0, 0, "rst_cyc");
        for (int k = 0; k < 6; k++)
            a_cycle(0, 2'd0, 2'd0, 3'b010, 0, 0, "rst_run");
        a_cycle(0, 2'd0, 2'd0, 3'b010, 0, 1, "rst_wd_win");
        a_cycle(1, 2'd1, 2'd0, 3'b010, 8, 0, "rst_br1_new");
        ifa.rd_req_i = 1'b0;
        ifa.en_i = 1'b0;
        ifa.br_vld_i = '0;

        // Overflow on the 4-bit monitors: 20 counted branches on ch0.
        s_set(1, 2'b00, 2'b00, 0, 0);
        step();
        for (int k = 1; k <= 20; k++) begin
            if (k == 16) begin
                chk("sat_ovf_pre",  {30'd0, ifs.ovf_o}, 0);
                chk("wrap_ovf_pre", {30'd0, ifw.ovf_o}, 0);
            end
            s_set(1, 2'b01, (k % 4 == 0) ? 2'b01 : 2'b10, 1, 0);
            step();
        end
        s_set(1, 2'b00, 2'b00, 0, 0);
        chk("sat_ovf",  {30'd0, ifs.ovf_o}, 1);
        chk("wrap_ovf", {30'd0, ifw.ovf_o}, 1);
        s_rd(1'b0, 2'd0, 15, 4, "s_br0");
        s_rd(1'b0, 2'd1, 5,  5, "s_ms0");
        s_rd(1'b1, 2'd2, 15, 6, "s_cyc");
        s_rd(1'b0, 2'd3, 15, 4, "s_ins");
        s_rd(1'b1, 2'd0, 0,  0, "s_br1");
        ifs.rd_req_i = 1'b0;
        ifw.rd_req_i = 1'b0;
        step();
        chk("s_noreq_ack",  {31'd0, ifs.rd_ack_o}, 0);
        chk("s_noreq_data", {28'd0, ifw.rd_data_o}, 0);
        chk("sat_ovf_sticky",  {30'd0, ifs.ovf_o}, 1);
        chk("wrap_ovf_sticky", {30'd0, ifw.ovf_o}, 1);

        s_set(1, 2'b00, 2'b00, 0, 1);
        step();
        s_set(1, 2'b00, 2'b00, 0, 0);
        chk("sat_ovf_clr",  {30'd0, ifs.ovf_o}, 0);
        chk("wrap_ovf_clr", {30'd0, ifw.ovf_o}, 0);
        s_rd(1'b0, 2'd2, 0, 0, "s_clr_cyc");
        s_rd(1'b0, 2'd0, 0, 0, "s_clr_br0");
        ifs.rd_req_i = 1'b0;
        ifw.rd_req_i = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
